// File: rtl/dmem_resp_pkg.sv
// Shared definitions for the data-memory responder:
//   - access size encodings carried on the request channel
//   - FSM state encoding and wait-counter width
//   - req_error(): misalignment / reserved-size / out-of-range classifier
package dmem_resp_pkg;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;
  localparam logic [1:0] SZ_RSVD = 2'b11;

  localparam int unsigned CNT_W = 4;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_WAIT   = 2'd1,
    ST_ACCESS = 2'd2,
    ST_RESP   = 2'd3
  } state_e;

  // The word index is compared un-wrapped, so any address at or beyond the
  // end of the RAM is an error regardless of its upper bits.
  function automatic logic req_error(input logic [1:0]  size,
                                     input logic [31:0] addr,
                                     input int unsigned depth_words);
    logic bad_align;
    case (size)
      SZ_BYTE: bad_align = 1'b0;
      SZ_HALF: bad_align = addr[0];
      SZ_WORD: bad_align = (addr[1:0] != 2'b00);
      default: bad_align = 1'b1;
    endcase
    return bad_align || ({2'b00, addr[31:2]} >= depth_words);
  endfunction

endpackage

// File: rtl/data_mem_responder_if.sv
// Request/response channels between the memory stage (master) and the
// data-memory responder (slave).
//   req_*  : valid/ready request channel (write, size, signed, addr, wdata)
//   resp_* : valid/ready response channel (rdata, error)
interface data_mem_responder_if;

  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [1:0]  req_size;
  logic        req_signed;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic        resp_ready;
  logic [31:0] resp_rdata;
  logic        resp_error;

  modport master (
    output req_valid, req_write, req_size, req_signed, req_addr, req_wdata,
    output resp_ready,
    input  req_ready, resp_valid, resp_rdata, resp_error
  );

  modport slave (
    input  req_valid, req_write, req_size, req_signed, req_addr, req_wdata,
    input  resp_ready,
    output req_ready, resp_valid, resp_rdata, resp_error
  );

endinterface

// File: rtl/mem_lane_align.sv
// Little-endian byte-lane steering for the data-memory responder.
//   size_i, signed_i, lane_i : captured access size, sign mode, Addr[1:0]
//   wdata_i                  : right-justified store data
//   old_word_i               : current RAM word (merge base for stores)
//   rd_word_i                : RAM word to extract load data from
//   st_word_o                : merged store word
//   ld_word_o                : right-justified, extended load data
module mem_lane_align
  import dmem_resp_pkg::*;
(
  input  logic [1:0]  size_i,
  input  logic        signed_i,
  input  logic [1:0]  lane_i,
  input  logic [31:0] wdata_i,
  input  logic [31:0] old_word_i,
  input  logic [31:0] rd_word_i,
  output logic [31:0] st_word_o,
  output logic [31:0] ld_word_o
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  assign byte_sel = rd_word_i[{lane_i, 3'b000} +: 8];
  assign half_sel = rd_word_i[{lane_i[1], 4'b0000} +: 16];

  always_comb begin
    st_word_o = old_word_i;
    case (size_i)
      SZ_BYTE: st_word_o[{lane_i, 3'b000} +: 8]     = wdata_i[7:0];
      SZ_HALF: st_word_o[{lane_i[1], 4'b0000} +: 16] = wdata_i[15:0];
      SZ_WORD: st_word_o = wdata_i;
      default: st_word_o = old_word_i;
    endcase
  end

  always_comb begin
    ld_word_o = '0;
    case (size_i)
      SZ_BYTE: ld_word_o = {{24{signed_i & byte_sel[7]}}, byte_sel};
      SZ_HALF: ld_word_o = {{16{signed_i & half_sel[15]}}, half_sel};
      SZ_WORD: ld_word_o = rd_word_i;
      default: ld_word_o = '0;
    endcase
  end

endmodule

// File: rtl/data_mem_responder.sv
// Data-memory responder: serves byte/half/word loads and stores from the
// memory stage against a word-organised RAM, with WAIT_CYCLES wait states
// between request accept and the RAM access.
//   clk_i  : clock, rising edge
//   rst_ni : asynchronous active-low reset (RAM contents are not cleared)
//   bus    : request/response channels (slave side)
//
// state     | meaning
// ST_IDLE   | ready for a request; captures it on accept
// ST_WAIT   | wait states, counter runs down to 0
// ST_ACCESS | single cycle: store commits or load data registered
// ST_RESP   | response valid, held until resp_ready
module data_mem_responder
  import dmem_resp_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter int unsigned WAIT_CYCLES = 2
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  data_mem_responder_if.slave  bus
);

  localparam int unsigned IDX_W = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam logic [CNT_W-1:0] CNT_INIT =
    (WAIT_CYCLES > 0) ? CNT_W'(WAIT_CYCLES - 1) : '0;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               wr_q, wr_d;
  logic [1:0]         size_q, size_d;
  logic               sgn_q, sgn_d;
  logic [31:0]        addr_q, addr_d;
  logic [31:0]        wdata_q, wdata_d;
  logic [31:0]        rdata_q, rdata_d;
  logic               rerr_q, rerr_d;

  logic [31:0]        ram [DEPTH_WORDS];
  logic               acc_err, cur_err;
  logic [IDX_W-1:0]   idx;
  logic [31:0]        ram_word, st_word, ld_word;

  // acc_err steers the accept decision; cur_err re-derives the same flag
  // from the captured request, so no separate error register is needed.
  assign acc_err  = req_error(bus.req_size, bus.req_addr, DEPTH_WORDS);
  assign cur_err  = req_error(size_q, addr_q, DEPTH_WORDS);
  assign idx      = addr_q[IDX_W+1:2];
  assign ram_word = ram[idx];

  mem_lane_align u_align (
    .size_i     (size_q),
    .signed_i   (sgn_q),
    .lane_i     (addr_q[1:0]),
    .wdata_i    (wdata_q),
    .old_word_i (ram_word),
    .rd_word_i  (ram_word),
    .st_word_o  (st_word),
    .ld_word_o  (ld_word)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    wr_d    = wr_q;
    size_d  = size_q;
    sgn_d   = sgn_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    rerr_d  = rerr_q;
    case (state_q)
      ST_IDLE: begin
        if (bus.req_valid) begin
          wr_d    = bus.req_write;
          size_d  = bus.req_size;
          sgn_d   = bus.req_signed;
          addr_d  = bus.req_addr;
          wdata_d = bus.req_wdata;
          // Errors skip the wait states entirely.
          if ((WAIT_CYCLES > 0) && !acc_err) begin
            state_d = ST_WAIT;
            cnt_d   = CNT_INIT;
          end else begin
            state_d = ST_ACCESS;
            cnt_d   = '0;
          end
        end
      end
      ST_WAIT: begin
        if (cnt_q == '0) state_d = ST_ACCESS;
        else             cnt_d   = cnt_q - 1'b1;
      end
      ST_ACCESS: begin
        rdata_d = (cur_err || wr_q) ? '0 : ld_word;
        rerr_d  = cur_err;
        state_d = ST_RESP;
      end
      ST_RESP: begin
        if (bus.resp_ready) begin
          state_d = ST_IDLE;
          rdata_d = '0;
          rerr_d  = 1'b0;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      wr_q    <= 1'b0;
      size_q  <= '0;
      sgn_q   <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      rerr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      wr_q    <= wr_d;
      size_q  <= size_d;
      sgn_q   <= sgn_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      rerr_q  <= rerr_d;
    end
  end

  // A reset before the ACCESS exit edge leaves state_q out of ST_ACCESS,
  // which is what drops an in-flight store.
  always_ff @(posedge clk_i) begin
    if ((state_q == ST_ACCESS) && wr_q && !cur_err) ram[idx] <= st_word;
  end

  assign bus.req_ready  = (state_q == ST_IDLE);
  assign bus.resp_valid = (state_q == ST_RESP);
  assign bus.resp_rdata = rdata_q;
  assign bus.resp_error = rerr_q;

endmodule

// File: tb/tb_data_mem_responder.sv
module tb_data_mem_responder;
  import dmem_resp_pkg::*;

  localparam int unsigned DEPTH = 1024;
  localparam int unsigned NWAIT = 2;

  typedef struct {
    logic        w;
    logic [1:0]  sz;
    logic        sg;
    logic [31:0] a;
    logic [31:0] wd;
    logic [31:0] xrd;
    logic        xer;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  int   n_cmp = 0;
  int   n_bad = 0;
  logic [7:0] ref_mem [DEPTH*4];

  data_mem_responder_if bus();

  data_mem_responder #(.DEPTH_WORDS(DEPTH), .WAIT_CYCLES(NWAIT)) dut (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .bus    (bus)
  );

  always #5 clk = ~clk;

  // Byte-addressed reference memory; applies stores and returns the
  // expected response for any request.
  function automatic void ref_access(input logic w, input logic [1:0] sz,
                                     input logic sg, input logic [31:0] a,
                                     input logic [31:0] wd,
                                     output logic [31:0] rd, output logic er);
    int nbytes;
    logic [31:0] v;
    nbytes = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
    er = (sz == 2'd3) || ((a % nbytes) != 0) || (a >= DEPTH*4);
    rd = '0;
    if (!er) begin
      if (w) begin
        for (int i = 0; i < nbytes; i++) ref_mem[a+i] = wd[8*i +: 8];
      end else begin
        v = '0;
        for (int i = 0; i < nbytes; i++) v[8*i +: 8] = ref_mem[a+i];
        if (sg && nbytes < 4 && v[8*nbytes-1]) v = v | (32'hFFFF_FFFF << (8*nbytes));
        rd = v;
      end
    end
  endfunction

  // Issues one request, waits (bounded) for the response, holds off
  // resp_ready for 'hold' cycles, then completes the handshake.
  task automatic do_req(input logic w, input logic [1:0] sz, input logic sg,
                        input logic [31:0] a, input logic [31:0] wd, input int hold,
                        output logic [31:0] rd, output logic er, output int lat);
    int guard;
    @(negedge clk);
    guard = 0;
    while (!bus.req_ready && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    bus.req_valid = 1'b1; bus.req_write = w; bus.req_size = sz;
    bus.req_signed = sg; bus.req_addr = a; bus.req_wdata = wd;
    @(posedge clk); #1;
    bus.req_valid  = 1'b0;
    bus.req_write  = 1'($urandom);
    bus.req_size   = 2'($urandom);
    bus.req_signed = 1'($urandom);
    bus.req_addr   = $urandom;
    bus.req_wdata  = $urandom;
    lat = 0;
    while (!bus.resp_valid && lat < 50) begin
      @(posedge clk); #1;
      lat++;
    end
    if (!bus.resp_valid) lat = -1;
    rd = bus.resp_rdata;
    er = bus.resp_error;
    repeat (hold) @(posedge clk);
    @(negedge clk); bus.resp_ready = 1'b1;
    @(posedge clk); #1; bus.resp_ready = 1'b0;
  endtask

  task automatic test_reset();
    #2 rst_n = 1'b0;
    #2;
    n_cmp++; if (bus.req_ready !== 1'b1) begin n_bad++; $display("FAIL reset_req_ready: got %b want 1", bus.req_ready); end
    n_cmp++; if (bus.resp_valid !== 1'b0) begin n_bad++; $display("FAIL reset_resp_valid: got %b want 0", bus.resp_valid); end
    n_cmp++; if (bus.resp_rdata !== 32'h0) begin n_bad++; $display("FAIL reset_resp_rdata: got %h want 0", bus.resp_rdata); end
    n_cmp++; if (bus.resp_error !== 1'b0) begin n_bad++; $display("FAIL reset_resp_error: got %b want 0", bus.resp_error); end
    @(negedge clk); rst_n = 1'b1;
  endtask

  task automatic test_directed();
    vec_t v[16];
    logic [31:0] rd, mrd;
    logic er, mer;
    int lat, xlat;
    v[0]  = '{1'b1, SZ_WORD, 1'b0, 32'h10,  32'hDEADBEEF, 32'h0,        1'b0};
    v[1]  = '{1'b0, SZ_WORD, 1'b0, 32'h10,  32'h0,        32'hDEADBEEF, 1'b0};
    v[2]  = '{1'b1, SZ_WORD, 1'b0, 32'h10,  32'h0,        32'h0,        1'b0};
    v[3]  = '{1'b1, SZ_BYTE, 1'b0, 32'h11,  32'h00000080, 32'h0,        1'b0};
    v[4]  = '{1'b0, SZ_BYTE, 1'b1, 32'h11,  32'h0,        32'hFFFFFF80, 1'b0};
    v[5]  = '{1'b0, SZ_BYTE, 1'b0, 32'h11,  32'h0,        32'h00000080, 1'b0};
    v[6]  = '{1'b0, SZ_WORD, 1'b0, 32'h10,  32'h0,        32'h00008000, 1'b0};
    v[7]  = '{1'b1, SZ_HALF, 1'b0, 32'h22,  32'h0000BEEF, 32'h0,        1'b0};
    v[8]  = '{1'b0, SZ_HALF, 1'b1, 32'h22,  32'h0,        32'hFFFFBEEF, 1'b0};
    v[9]  = '{1'b0, SZ_HALF, 1'b0, 32'h22,  32'h0,        32'h0000BEEF, 1'b0};
    v[10] = '{1'b0, SZ_HALF, 1'b1, 32'h23,  32'h0,        32'h0,        1'b1};
    v[11] = '{1'b1, SZ_WORD, 1'b0, 32'd4096, 32'hCAFEF00D, 32'h0,       1'b1};
    v[12] = '{1'b0, SZ_WORD, 1'b0, 32'h0,   32'h0,        32'h0,        1'b0};
    v[13] = '{1'b0, SZ_RSVD, 1'b0, 32'h0,   32'h0,        32'h0,        1'b1};
    v[14] = '{1'b0, SZ_WORD, 1'b1, 32'h20,  32'h0,        32'hBEEF0000, 1'b0};
    v[15] = '{1'b0, SZ_BYTE, 1'b0, 32'd4095, 32'h0,       32'h0,        1'b0};
    for (int i = 0; i < 16; i++) begin
      ref_access(v[i].w, v[i].sz, v[i].sg, v[i].a, v[i].wd, mrd, mer);
      do_req(v[i].w, v[i].sz, v[i].sg, v[i].a, v[i].wd, 0, rd, er, lat);
      xlat = v[i].xer ? 1 : int'(NWAIT) + 1;
      n_cmp++; if (rd !== v[i].xrd) begin n_bad++; $display("FAIL dir%0d_rdata: got %h want %h", i, rd, v[i].xrd); end
      n_cmp++; if (er !== v[i].xer) begin n_bad++; $display("FAIL dir%0d_error: got %b want %b", i, er, v[i].xer); end
      n_cmp++; if (lat != xlat) begin n_bad++; $display("FAIL dir%0d_latency: got %0d want %0d", i, lat, xlat); end
    end
  endtask

  task automatic test_stall();
    logic [31:0] erd, held, nwd, rd;
    logic eer, er;
    int lat;
    ref_access(1'b0, SZ_WORD, 1'b0, 32'h10, 32'h0, erd, eer);
    @(negedge clk);
    bus.req_valid = 1'b1; bus.req_write = 1'b0; bus.req_size = SZ_WORD;
    bus.req_signed = 1'b0; bus.req_addr = 32'h10; bus.req_wdata = 32'h0;
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    lat = 0;
    while (!bus.resp_valid && lat < 50) begin @(posedge clk); #1; lat++; end
    held = bus.resp_rdata;
    n_cmp++; if (held !== erd) begin n_bad++; $display("FAIL stall_rdata: got %h want %h", held, erd); end
    nwd = $urandom;
    bus.req_valid = 1'b1; bus.req_write = 1'b1; bus.req_size = SZ_WORD;
    bus.req_addr = 32'h80; bus.req_wdata = nwd;
    for (int k = 0; k < 5; k++) begin
      @(posedge clk); #1;
      n_cmp++; if (bus.resp_valid !== 1'b1) begin n_bad++; $display("FAIL stall%0d_resp_valid: got %b want 1", k, bus.resp_valid); end
      n_cmp++; if (bus.resp_rdata !== held) begin n_bad++; $display("FAIL stall%0d_rdata_stable: got %h want %h", k, bus.resp_rdata, held); end
      n_cmp++; if (bus.req_ready !== 1'b0) begin n_bad++; $display("FAIL stall%0d_req_ready: got %b want 0", k, bus.req_ready); end
    end
    @(negedge clk); bus.resp_ready = 1'b1;
    @(posedge clk); #1; bus.resp_ready = 1'b0;
    n_cmp++; if (bus.resp_valid !== 1'b0) begin n_bad++; $display("FAIL release_resp_valid: got %b want 0", bus.resp_valid); end
    n_cmp++; if (bus.req_ready !== 1'b1) begin n_bad++; $display("FAIL release_req_ready: got %b want 1", bus.req_ready); end
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    n_cmp++; if (bus.req_ready !== 1'b0) begin n_bad++; $display("FAIL next_accept_req_ready: got %b want 0", bus.req_ready); end
    ref_access(1'b1, SZ_WORD, 1'b0, 32'h80, nwd, erd, eer);
    lat = 0;
    while (!bus.resp_valid && lat < 50) begin @(posedge clk); #1; lat++; end
    n_cmp++; if (lat != int'(NWAIT) + 1) begin n_bad++; $display("FAIL next_latency: got %0d want %0d", lat, NWAIT + 1); end
    @(negedge clk); bus.resp_ready = 1'b1;
    @(posedge clk); #1; bus.resp_ready = 1'b0;
    do_req(1'b0, SZ_WORD, 1'b0, 32'h80, 32'h0, 0, rd, er, lat);
    n_cmp++; if (rd !== nwd) begin n_bad++; $display("FAIL next_store_data: got %h want %h", rd, nwd); end
  endtask

  task automatic test_reset_mid();
    logic [31:0] rd, mrd;
    logic er, mer;
    int lat;
    @(negedge clk);
    bus.req_valid = 1'b1; bus.req_write = 1'b1; bus.req_size = SZ_WORD;
    bus.req_signed = 1'b0; bus.req_addr = 32'h40; bus.req_wdata = 32'h12345678;
    @(posedge clk); #1; bus.req_valid = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    n_cmp++; if (bus.req_ready !== 1'b1) begin n_bad++; $display("FAIL rstmid_req_ready: got %b want 1", bus.req_ready); end
    n_cmp++; if (bus.resp_valid !== 1'b0) begin n_bad++; $display("FAIL rstmid_resp_valid: got %b want 0", bus.resp_valid); end
    @(negedge clk); rst_n = 1'b1;
    do_req(1'b0, SZ_WORD, 1'b0, 32'h40, 32'h0, 0, rd, er, lat);
    n_cmp++; if (rd !== 32'h0) begin n_bad++; $display("FAIL rstmid_store_lost: got %h want 00000000", rd); end
    // Reset arriving in RESP must keep the already-committed store.
    @(negedge clk);
    bus.req_valid = 1'b1; bus.req_write = 1'b1; bus.req_size = SZ_WORD;
    bus.req_addr = 32'h48; bus.req_wdata = 32'hA5A55A5A;
    @(posedge clk); #1; bus.req_valid = 1'b0;
    lat = 0;
    while (!bus.resp_valid && lat < 50) begin @(posedge clk); #1; lat++; end
    rst_n = 1'b0;
    #1;
    n_cmp++; if (bus.resp_valid !== 1'b0) begin n_bad++; $display("FAIL rstresp_resp_valid: got %b want 0", bus.resp_valid); end
    @(negedge clk); rst_n = 1'b1;
    ref_access(1'b1, SZ_WORD, 1'b0, 32'h48, 32'hA5A55A5A, mrd, mer);
    do_req(1'b0, SZ_WORD, 1'b0, 32'h48, 32'h0, 0, rd, er, lat);
    n_cmp++; if (rd !== 32'hA5A55A5A) begin n_bad++; $display("FAIL rstresp_store_kept: got %h want a5a55a5a", rd); end
  endtask

  task automatic test_random();
    logic [31:0] a, wd, rd, mrd;
    logic [1:0] sz;
    logic w, sg, er, mer;
    int lat, xlat, r;
    for (int i = 0; i < 80; i++) begin
      r = $urandom_range(0, 9);
      if (r < 7)       a = $urandom_range(0, 127);
      else if (r == 7) a = $urandom_range(DEPTH*4 - 8, DEPTH*4 + 7);
      else             a = $urandom;
      w  = 1'($urandom);
      sz = 2'($urandom);
      sg = 1'($urandom);
      wd = $urandom;
      ref_access(w, sz, sg, a, wd, mrd, mer);
      do_req(w, sz, sg, a, wd, $urandom_range(0, 3), rd, er, lat);
      xlat = mer ? 1 : int'(NWAIT) + 1;
      n_cmp++; if (rd !== mrd) begin n_bad++; $display("FAIL rnd%0d_rdata: got %h want %h (a=%h sz=%0d w=%b s=%b)", i, rd, mrd, a, sz, w, sg); end
      n_cmp++; if (er !== mer) begin n_bad++; $display("FAIL rnd%0d_error: got %b want %b (a=%h sz=%0d)", i, er, mer, a, sz); end
      n_cmp++; if (lat != xlat) begin n_bad++; $display("FAIL rnd%0d_latency: got %0d want %0d", i, lat, xlat); end
    end
  endtask

  initial begin
    for (int i = 0; i < DEPTH*4; i++) ref_mem[i] = 8'h00;
    bus.req_valid = 1'b0; bus.req_write = 1'b0; bus.req_size = 2'b00;
    bus.req_signed = 1'b0; bus.req_addr = '0; bus.req_wdata = '0;
    bus.resp_ready = 1'b0;
    test_reset();
    test_directed();
    test_stall();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
